// File: rtl/bonus_timer_axil_slave.sv
// AXI4-Lite register block for the bonus-shot countdown timer: CTRL/RELOAD/COUNT/STATUS,
// prescaled tick, expiry interrupt and a bonus_active flag for the scoring logic.
module bonus_timer_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PRESCALE           = 50000000,
  parameter int RELOAD_RST         = 30
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              irq,
  output logic                              bonus_active
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] A_CTRL = 2'd0, A_RELOAD = 2'd1, A_STATUS = 2'd3;

  logic          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [2:0]    r_ctrl;  // [0]EN [1]AUTO_RELOAD [2]IRQ_EN
  logic [DW-1:0] r_reload, r_count;
  logic          r_expired, r_reload_pend, r_irq, r_bonus;
  logic [PW-1:0] r_presc;

  logic          w_wr, w_rd, w_tick, w_expire, w_load, w_ctrl_wr, w_w1c;
  logic [1:0]    w_waddr;
  logic [DW-1:0] w_reload_nxt, w_rdata;
  logic          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_waddr   = S_AXI_AWADDR[3:2];
  assign w_wr      = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd      = r_arready & S_AXI_ARVALID;
  assign w_ctrl_wr = w_wr & (w_waddr == A_CTRL) & S_AXI_WSTRB[0];
  assign w_load    = w_ctrl_wr & S_AXI_WDATA[0] & ~r_ctrl[0];
  assign w_w1c     = w_wr & (w_waddr == A_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign w_tick    = r_ctrl[0] & (r_presc == PW'(PRESCALE - 1));
  // Expiry covers both the normal 1->0 step and a tick that finds COUNT already 0.
  assign w_expire  = w_tick & (r_count <= DW'(1));

  always_comb begin
    w_reload_nxt = r_reload;
    for (int b = 0; b < DW/8; b++)
      if (S_AXI_WSTRB[b]) w_reload_nxt[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
  end

  always_comb begin
    w_rdata = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    w_rdata = {{(DW-3){1'b0}}, r_ctrl};
      2'd1:    w_rdata = r_reload;
      2'd2:    w_rdata = r_count;
      default: w_rdata = {{(DW-1){1'b0}}, r_expired};
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready     <= 1'b0;
      r_bvalid      <= 1'b0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_ctrl        <= '0;
      r_reload      <= DW'(RELOAD_RST);
      r_count       <= '0;
      r_expired     <= 1'b0;
      r_reload_pend <= 1'b0;
      r_presc       <= '0;
      r_irq         <= 1'b0;
      r_bonus       <= 1'b0;
    end else begin
      r_awready <= ~r_awready & ~r_bvalid & S_AXI_AWVALID & S_AXI_WVALID;
      if (w_wr)              r_bvalid <= 1'b1;
      else if (S_AXI_BREADY) r_bvalid <= 1'b0;

      r_arready <= ~r_arready & ~r_rvalid & S_AXI_ARVALID;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end

      if (w_wr && w_waddr == A_RELOAD) r_reload <= w_reload_nxt;

      if (!r_ctrl[0] || w_load || w_tick) r_presc <= '0;
      else                                r_presc <= r_presc + 1'b1;

      r_reload_pend <= 1'b0;
      if (w_load || r_reload_pend)     r_count <= r_reload;
      else if (w_tick && r_count != 0) r_count <= r_count - DW'(1);

      if (w_expire)   r_expired <= 1'b1;
      else if (w_w1c) r_expired <= 1'b0;

      if (w_expire) begin
        if (r_count == DW'(1) && r_ctrl[1]) r_reload_pend <= 1'b1;
        else                                r_ctrl[0]     <= 1'b0;
      end
      // A software CTRL write lands after the hardware EN clear and so wins.
      if (w_ctrl_wr) r_ctrl <= S_AXI_WDATA[2:0];

      r_irq   <= r_expired & r_ctrl[2];
      r_bonus <= r_ctrl[0] & (r_count != 0);
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = r_irq;
  assign bonus_active  = r_bonus;
endmodule
